// File: rtl/pulse_seq_ctrl_pkg.sv
// Shared state encodings, default widths and small helpers for the pulse sequencer.
package pulse_seq_ctrl_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_NEXT = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam int DEF_STEPS = 4;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_REP_W = 16;

  // DONE is deliberately excluded: the host may reprogram the table during the done pulse
  function automatic logic is_busy_state(input logic [2:0] st);
    return (st == ST_LOAD) || (st == ST_RUN) || (st == ST_NEXT);
  endfunction

endpackage

// File: rtl/pulse_seq_ctrl_if.sv
// Host-side config/control/status bundle of the pulse sequencer, plus the io pin.
interface pulse_seq_ctrl_if import pulse_seq_ctrl_pkg::*; #(
  parameter int STEPS = DEF_STEPS,
  parameter int CNT_W = DEF_CNT_W,
  parameter int REP_W = DEF_REP_W
);
  localparam int IDX_W = $clog2(STEPS);

  logic             cfg_we;
  logic [IDX_W-1:0] cfg_addr;
  logic [CNT_W-1:0] cfg_half;
  logic [REP_W-1:0] cfg_reps;
  logic             start;
  logic             abort;
  logic             loop_en;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] step_idx;
  logic             io;

  modport master (
    output cfg_we, cfg_addr, cfg_half, cfg_reps, start, abort, loop_en,
    input  busy, done, step_idx, io
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_half, cfg_reps, start, abort, loop_en,
    output busy, done, step_idx, io
  );

endinterface

// File: rtl/pulse_seq_ctrl_table.sv
// Step table: STEPS entries of {half, reps}, synchronous write, asynchronous read.
module pulse_seq_table import pulse_seq_ctrl_pkg::*; #(
  parameter int STEPS = DEF_STEPS,
  parameter int CNT_W = DEF_CNT_W,
  parameter int REP_W = DEF_REP_W,
  localparam int IDX_W = $clog2(STEPS),
  localparam int ENT_W = CNT_W + REP_W
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [ENT_W-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [ENT_W-1:0] rdata
);

  logic [ENT_W-1:0] mem [STEPS];

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STEPS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pulse_seq_ctrl.sv
// Table-driven square-wave sequencer: walks the step table, toggling io every half
// cycles for reps toggles per step, with start/abort control and optional looping.
module pulse_seq_ctrl import pulse_seq_ctrl_pkg::*; #(
  parameter int STEPS = DEF_STEPS,
  parameter int CNT_W = DEF_CNT_W,
  parameter int REP_W = DEF_REP_W
) (
  input  logic            sysclk,
  input  logic            rst_n,
  pulse_seq_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(STEPS);
  localparam int ENT_W = CNT_W + REP_W;

  logic [2:0]       state;
  logic [IDX_W-1:0] step_idx;
  logic [CNT_W-1:0] cnt;
  logic [REP_W-1:0] rem;
  logic             io_q;
  logic             busy;
  logic             tbl_we;
  logic [ENT_W-1:0] tbl_rdata;
  logic [CNT_W-1:0] cur_half;
  logic [REP_W-1:0] cur_reps;
  logic             last_step;

  assign busy      = is_busy_state(state);
  assign tbl_we    = bus.cfg_we & ~busy;
  assign cur_half  = tbl_rdata[ENT_W-1:REP_W];
  assign cur_reps  = tbl_rdata[REP_W-1:0];
  assign last_step = (step_idx == IDX_W'(STEPS - 1));

  pulse_seq_table #(
    .STEPS (STEPS),
    .CNT_W (CNT_W),
    .REP_W (REP_W)
  ) u_table (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .we     (tbl_we),
    .waddr  (bus.cfg_addr),
    .wdata  ({bus.cfg_half, bus.cfg_reps}),
    .raddr  (step_idx),
    .rdata  (tbl_rdata)
  );

  // abort outranks every other transition once the sequencer has left IDLE
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      step_idx <= '0;
      cnt      <= '0;
      rem      <= '0;
      io_q     <= 1'b0;
    end else if (bus.abort && (state != ST_IDLE)) begin
      state    <= ST_IDLE;
      step_idx <= '0;
      cnt      <= '0;
      rem      <= '0;
      io_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            state    <= ST_LOAD;
            step_idx <= '0;
          end
        end
        ST_LOAD: begin
          cnt <= '0;
          rem <= cur_reps;
          if ((cur_half == '0) || (cur_reps == '0)) state <= ST_NEXT;
          else                                      state <= ST_RUN;
        end
        ST_RUN: begin
          if (cnt == cur_half - CNT_W'(1)) begin
            io_q <= ~io_q;
            cnt  <= '0;
            rem  <= rem - REP_W'(1);
            if (rem == REP_W'(1)) state <= ST_NEXT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_NEXT: begin
          if (!last_step) begin
            step_idx <= step_idx + IDX_W'(1);
            state    <= ST_LOAD;
          end else if (bus.loop_en) begin
            step_idx <= '0;
            state    <= ST_LOAD;
          end else begin
            step_idx <= '0;
            io_q     <= 1'b0;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          io_q  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = (state == ST_DONE);
  assign bus.step_idx = step_idx;
  assign bus.io       = io_q;

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Self-checking bench for pulse_seq_ctrl: directed vectors, corner sequences and
// randomized tables checked against a cycle-schedule model of the step table.
module tb_pulse_seq_ctrl;

  localparam int STEPS = 4;
  localparam int CNT_W = 8;
  localparam int REP_W = 4;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;

  always #5 sysclk = ~sysclk;

  pulse_seq_ctrl_if #(.STEPS(STEPS), .CNT_W(CNT_W), .REP_W(REP_W)) bus ();

  pulse_seq_ctrl #(.STEPS(STEPS), .CNT_W(CNT_W), .REP_W(REP_W)) dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  typedef struct {
    bit [3:0][7:0] half;
    bit [3:0][3:0] reps;
    int            exp_busy;
    int            exp_tog;
    string         name;
  } vec_t;

  typedef struct {
    bit busy;
    bit io;
    bit done;
    int idx;
    bit chk_idx;
  } exp_t;

  int   n_checks = 0;
  int   n_fails  = 0;
  int   sh_half [STEPS];
  int   sh_reps [STEPS];
  exp_t exp_q [$];
  int   pass_len;
  vec_t vecs [6];

  task automatic tick();
    @(negedge sysclk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic vec_t mk(input int h0, input int r0, input int h1, input int r1,
                              input int h2, input int r2, input int h3, input int r3,
                              input int b, input int t, input string nm);
    vec_t v;
    v.half[0] = 8'(h0); v.reps[0] = 4'(r0);
    v.half[1] = 8'(h1); v.reps[1] = 4'(r1);
    v.half[2] = 8'(h2); v.reps[2] = 4'(r2);
    v.half[3] = 8'(h3); v.reps[3] = 4'(r3);
    v.exp_busy = b;
    v.exp_tog  = t;
    v.name     = nm;
    return v;
  endfunction

  task automatic writeEntry(input int a, input int h, input int r);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 2'(a);
    bus.cfg_half = 8'(h);
    bus.cfg_reps = 4'(r);
    tick();
    bus.cfg_we   = 1'b0;
    sh_half[a]   = h;
    sh_reps[a]   = r;
  endtask

  task automatic loadTable(input bit [3:0][7:0] h, input bit [3:0][3:0] r);
    for (int i = 0; i < STEPS; i++) writeEntry(i, int'(h[i]), int'(r[i]));
  endtask

  function automatic exp_t ex(input bit b, input bit o, input bit d, input int i, input bit c);
    exp_t e;
    e.busy = b; e.io = o; e.done = d; e.idx = i; e.chk_idx = c;
    return e;
  endfunction

  // Expected per-cycle outputs from the cycle after the start edge: each step is one
  // load cycle, half*reps run cycles toggling io every half cycles, then one next cycle.
  task automatic buildModel(input int passes);
    bit lvl = 1'b0;
    exp_q.delete();
    pass_len = 0;
    for (int s = 0; s < STEPS; s++)
      pass_len += (sh_half[s] != 0 && sh_reps[s] != 0) ? sh_half[s] * sh_reps[s] + 2 : 2;
    for (int p = 0; p < passes; p++) begin
      for (int s = 0; s < STEPS; s++) begin
        exp_q.push_back(ex(1'b1, lvl, 1'b0, s, 1'b1));
        if (sh_half[s] != 0 && sh_reps[s] != 0) begin
          exp_q.push_back(ex(1'b1, lvl, 1'b0, s, 1'b1));
          for (int t = 1; t <= sh_half[s] * sh_reps[s]; t++) begin
            if (t % sh_half[s] == 0) lvl = ~lvl;
            exp_q.push_back(ex(1'b1, lvl, 1'b0, s, 1'b1));
          end
        end else begin
          exp_q.push_back(ex(1'b1, lvl, 1'b0, s, 1'b1));
        end
      end
    end
    exp_q.push_back(ex(1'b0, 1'b0, 1'b1, 0, 1'b0));
    exp_q.push_back(ex(1'b0, 1'b0, 1'b0, 0, 1'b1));
  endtask

  task automatic runSeq(input int passes, input bit wr_on_start, input int wh, input int wr,
                        input bit inject);
    int drop_at;
    if (wr_on_start) begin
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 2'd0;
      bus.cfg_half = 8'(wh);
      bus.cfg_reps = 4'(wr);
      sh_half[0]   = wh;
      sh_reps[0]   = wr;
    end
    buildModel(passes);
    drop_at     = (passes - 1) * pass_len + 1;
    bus.loop_en = (passes > 1);
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.cfg_we  = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      checkOutput("seq busy", bus.busy, exp_q[k].busy);
      checkOutput("seq io", bus.io, exp_q[k].io);
      checkOutput("seq done", bus.done, exp_q[k].done);
      if (exp_q[k].chk_idx) checkOutput("seq step_idx", bus.step_idx, exp_q[k].idx);
      if (passes > 1 && k == drop_at) bus.loop_en = 1'b0;
      if (inject && exp_q[k].busy && $urandom_range(0, 2) == 0) begin
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 2'($urandom_range(0, 3));
        bus.cfg_half = 8'($urandom_range(1, 9));
        bus.cfg_reps = 4'($urandom_range(1, 9));
      end else begin
        bus.cfg_we = 1'b0;
      end
      tick();
    end
    bus.cfg_we  = 1'b0;
    bus.loop_en = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    int  busy_cnt = 0;
    int  tog      = 0;
    int  done_cnt = 0;
    int  n;
    bit  prev;
    loadTable(v.half, v.reps);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    prev = bus.io;
    for (n = 0; n < 400; n++) begin
      if (!bus.busy) break;
      busy_cnt++;
      if (bus.io !== prev) tog++;
      prev = bus.io;
      if (bus.done) done_cnt++;
      tick();
    end
    checkOutput({v.name, " ended"}, bus.busy, 0);
    checkOutput({v.name, " io in done"}, bus.io, 0);
    if (bus.done) done_cnt++;
    tick();
    if (bus.done) done_cnt++;
    tick();
    checkOutput({v.name, " busy cycles"}, busy_cnt, v.exp_busy);
    checkOutput({v.name, " toggles"}, tog, v.exp_tog);
    checkOutput({v.name, " done pulses"}, done_cnt, 1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int done_cnt;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_half = '0; bus.cfg_reps = '0;
    bus.start  = 1'b0; bus.abort    = 1'b0; bus.loop_en  = 1'b0;
    for (int i = 0; i < STEPS; i++) begin sh_half[i] = 0; sh_reps[i] = 0; end

    vecs[0] = mk(3, 4, 0, 0, 0, 0, 0, 0, 20, 4, "single");
    vecs[1] = mk(2, 1, 0, 5, 4, 0, 1, 2, 12, 3, "skipcarry");
    vecs[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 8, 0, "allskip");
    vecs[3] = mk(0, 0, 0, 0, 0, 0, 2, 3, 14, 3, "laststep");
    vecs[4] = mk(1, 15, 0, 0, 0, 0, 0, 0, 23, 15, "maxreps");
    vecs[5] = mk(0, 0, 255, 1, 0, 0, 0, 0, 263, 1, "maxhalf");

    // reset state, then a quiet idle period
    tick(); tick();
    checkOutput("reset io", bus.io, 0);
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset done", bus.done, 0);
    checkOutput("reset step_idx", bus.step_idx, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("idle io", bus.io, 0);
      checkOutput("idle busy", bus.busy, 0);
      checkOutput("idle done", bus.done, 0);
      checkOutput("idle step_idx", bus.step_idx, 0);
    end

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // cycle-accurate skip-and-carry, then looping with loop_en dropped in the third pass
    loadTable(vecs[1].half, vecs[1].reps);
    runSeq(1, 1'b0, 0, 0, 1'b0);
    loadTable(vecs[0].half, vecs[0].reps);
    writeEntry(0, 2, 2);
    runSeq(3, 1'b0, 0, 0, 1'b0);

    // abort in RUN while io is high
    writeEntry(0, 3, 4);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (n = 0; n < 50; n++) begin
      if (bus.io) break;
      tick();
    end
    checkOutput("abort io high seen", bus.io, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checkOutput("abort io", bus.io, 0);
    checkOutput("abort busy", bus.busy, 0);
    checkOutput("abort done", bus.done, 0);
    checkOutput("abort step_idx", bus.step_idx, 0);
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.done || bus.busy) done_cnt++;
    end
    checkOutput("abort quiet after", done_cnt, 0);

    // start and abort together in IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    checkOutput("start+abort busy", bus.busy, 0);
    tick();
    checkOutput("start+abort busy later", bus.busy, 0);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    tick();

    // all-skip table with loop_en spins forever until abort
    loadTable(vecs[2].half, vecs[2].reps);
    bus.loop_en = 1'b1;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    done_cnt    = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done || !bus.busy || bus.io) done_cnt++;
      tick();
    end
    checkOutput("skiploop stayed busy", done_cnt, 0);
    bus.abort = 1'b1;
    tick();
    bus.abort   = 1'b0;
    bus.loop_en = 1'b0;
    checkOutput("skiploop abort busy", bus.busy, 0);
    tick();

    // start held high across DONE restarts after one idle cycle
    writeEntry(0, 1, 1);
    bus.start = 1'b1;
    for (n = 0; n < 50; n++) begin
      tick();
      if (bus.done) break;
    end
    checkOutput("held start done seen", bus.done, 1);
    tick();
    checkOutput("held start idle gap", bus.busy, 0);
    tick();
    checkOutput("held start restart", bus.busy, 1);
    bus.start = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    tick();

    // config lockout while busy, then write on the start edge
    loadTable(vecs[0].half, vecs[0].reps);
    runSeq(1, 1'b0, 0, 0, 1'b1);
    runSeq(1, 1'b0, 0, 0, 1'b0);
    runSeq(1, 1'b1, 2, 2, 1'b0);

    // async reset mid-sequence clears registers and table without a clock edge
    writeEntry(0, 3, 4);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async rst busy", bus.busy, 0);
    checkOutput("async rst io", bus.io, 0);
    checkOutput("async rst step_idx", bus.step_idx, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < STEPS; i++) begin sh_half[i] = 0; sh_reps[i] = 0; end
    tick();
    runSeq(1, 1'b0, 0, 0, 1'b0);

    // randomized tables, pass counts and lockout traffic
    for (int it = 0; it < 12; it++) begin
      for (int s = 0; s < STEPS; s++)
        writeEntry(s, $urandom_range(0, 4), $urandom_range(0, 3));
      runSeq($urandom_range(1, 2), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
             $urandom_range(0, 3), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
